mult_seq: RTL and testbench
===========================

# mult_seq

Sequential, parametrised shift-and-add multiplier. It replaces the fixed 5x5 combinational array multiplier with an N x M multiplier that supports both unsigned and two's-complement operands. It trades latency for area: one partial product per clock, driven by a start/done handshake. It sits between the switch/register inputs and the LED/display outputs of the arithmetic datapath.

## Interface
- `WIDTH_A`, default 5: multiplicand width, must be >= 2.
- `WIDTH_B`, default 5: multiplier width, must be >= 2; also the iteration count.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: request. Sampled only while idle.
- `signed_mode`  in  1: 1 = operands are two's complement; 0 = unsigned. Captured with `start`.
- `a`  in  WIDTH_A: multiplicand, captured with `start`.
- `b`  in  WIDTH_B: multiplier, captured with `start`.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle pulse when `product` is updated.
- `product`  out  WIDTH_A+WIDTH_B: result. Held stable until the next completion.

## Operation
- **States.** The block has two states: IDLE and CALC.
- **IDLE + `start`=1.**
  - Capture `signed_mode`.
  - Capture the magnitudes |a| and |b|. In unsigned mode these are the raw values. In signed mode a negative operand is two's-complement negated; the most-negative value maps to 2^(W-1), which fits in W bits unsigned.
  - Capture `neg` = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the accumulator (WIDTH_A+WIDTH_B bits) and the iteration counter.
  - Go to CALC.
- **CALC, each cycle:**
  - If the multiplier LSB is 1, add |a| to the upper WIDTH_A+1 bits of the accumulator through the ripple adder.
  - Shift the accumulator and multiplier right by one (shift-add with the multiplier sharing the low accumulator bits is allowed).
  - Increment the counter.
- **Last iteration (counter = WIDTH_B-1):**
  - Write `product` = neg ? -result : result, truncated to WIDTH_A+WIDTH_B bits. This is exact for all inputs.
  - Pulse `done`.
  - Return to IDLE.
- **Masking.** `start` is ignored while in CALC. Operand inputs may change freely after capture without affecting the result.
- **Zero operands.** No early termination: a zero operand still takes the full WIDTH_B iterations.
- **Reset.** `rst_n` low at any time, including mid-CALC, does all of the following:
  - forces IDLE;
  - `busy`=0, `done`=0, `product`=0;
  - clears the accumulator and counter;
  - aborts the operation with no `done`.

## Timing
- **Reset values.** `busy`=0, `done`=0, `product`=0.
- **Start edge.** `start` is sampled at rising edge E0 while in IDLE. `busy`=1 from E0 until edge E(WIDTH_B).
- **Completion.**
  - `product` and `done`=1 are valid in the cycle after edge E(WIDTH_B), and `busy`=0 in that same cycle.
  - `done` deasserts at E(WIDTH_B+1) unless a new operation completes.
- **Back-to-back.** With `start` held high in the cycle where `done`=1, that start is accepted at E(WIDTH_B+1). Throughput is one result per WIDTH_B+1 cycles. `product` keeps the old value until the next completion.
- **Registered outputs.** `busy`, `done` and `product` are all registered; there is no combinational path from inputs to outputs.

## Structure
- **Shared package.** Holds the state encoding (IDLE, CALC) and the width helpers: PW = WIDTH_A+WIDTH_B, and counter width = clog2(WIDTH_B).
- **Sub-module `somador_n`.**
  - Parametrised N-bit ripple-carry adder built from the existing full-adder cell.
  - Inputs: a, b, cin. Outputs: sum, cout.
  - Instantiated once with N = WIDTH_A for the accumulate step.
  - Also reused for the final two's-complement negation (~x + 1) through a second instance.
- **Top module.** Holds the FSM, the operand/accumulator registers and the counter.

## Test plan
All cases use defaults WIDTH_A = WIDTH_B = 5.
- **Unsigned maximum.** a=31, b=31, signed_mode=0 → `done` 5 cycles after the start edge, `product`=961 (0x3C1), `busy` high for exactly 5 cycles.
- **Signed corners.**
  - a=-16 (0x10), b=-16 (0x10), signed_mode=1 → `product`=256 (0x100).
  - a=-3 (0x1D), b=7 → `product`=-21 (0x3EB).
  - The same bit patterns 0x1D × 7 with signed_mode=0 → 203 (0x0CB).
- **Zero and back-to-back.**
  - a=0, b=25 → `product`=0 after the full 5 cycles.
  - Then hold `start` high through `done` with a=5, b=6 → second `done` 6 cycles after the first, `product`=30.
- **Start while busy.** `start` pulsed with a=9, b=9 two cycles after an accepted 3×4 → single `done`, `product`=12, no second operation.
- **Reset mid-CALC.** Assert `rst_n`=0 asynchronously between clock edges at iteration 3 of 31×31 → `busy`, `done`, `product` go to 0 immediately. After release, no `done` appears. A new 2×3 then completes with `product`=6.
- **Sweep.** Exhaustive check of all 1024 operand pairs in both modes against a reference model; `done` latency is constant at 5 cycles.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and width helpers.
package mult_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Product width for a WA x WB multiply.
  function automatic int calc_pw(input int wa, input int wb);
    return wa + wb;
  endfunction

  // Iteration counter width; never narrower than one bit.
  function automatic int calc_cw(input int wb);
    return (wb <= 2) ? 1 : $clog2(wb);
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Start/done handshake and operand/result bus of the multiplier.
interface mult_seq_if
  import mult_seq_pkg::*;
#(
  parameter int WIDTH_A = 5,
  parameter int WIDTH_B = 5
);

  localparam int PW = calc_pw(WIDTH_A, WIDTH_B);

  logic               start;
  logic               signed_mode;
  logic [WIDTH_A-1:0] a;
  logic [WIDTH_B-1:0] b;
  logic               busy;
  logic               done;
  logic [PW-1:0]      product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/mult_seq_somador_n.sv
// N-bit ripple-carry adder built from a chain of full-adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module somador_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[N];

endmodule

// File: rtl/mult_seq.sv
// Sequential WIDTH_A x WIDTH_B shift-and-add multiplier, unsigned or
// two's complement. Operates on magnitudes, one partial product per
// clock, and applies the sign on the last iteration.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH_A = 5,
  parameter int WIDTH_B = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_seq_if.slave   bus
);

  localparam int PW = calc_pw(WIDTH_A, WIDTH_B);
  localparam int CW = calc_cw(WIDTH_B);
  localparam logic [CW-1:0] LAST = CW'(WIDTH_B - 1);

  state_t state, state_nxt;
  logic   ld, step, fin;

  logic               neg_r;
  logic [WIDTH_A-1:0] mag_a_r;
  logic [WIDTH_B-1:0] mplier_r;
  logic [PW-1:0]      acc_r;
  logic [CW-1:0]      cnt_r;
  logic               done_r;
  logic [PW-1:0]      product_r;

  logic [WIDTH_A-1:0] mag_a_in;
  logic [WIDTH_B-1:0] mag_b_in;
  logic [WIDTH_A-1:0] addend;
  logic [WIDTH_A-1:0] sum_hi;
  logic               cout_hi;
  logic [PW-1:0]      acc_nxt;
  logic [PW-1:0]      neg_sum;
  logic               neg_cout_unused;
  logic [PW-1:0]      zero_pw;

  // Magnitudes: negative signed operands are negated; the most-negative
  // value maps to 2^(W-1), which still fits unsigned in W bits.
  assign mag_a_in = (bus.signed_mode & bus.a[WIDTH_A-1]) ? WIDTH_A'(~bus.a + 1'b1) : bus.a;
  assign mag_b_in = (bus.signed_mode & bus.b[WIDTH_B-1]) ? WIDTH_B'(~bus.b + 1'b1) : bus.b;

  assign addend  = mplier_r[0] ? mag_a_r : '0;
  assign zero_pw = '0;

  somador_n #(.N(WIDTH_A)) u_acc_add (
    .a    (acc_r[PW-1:WIDTH_B]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum_hi),
    .cout (cout_hi)
  );

  // Carry becomes the new top bit; the whole accumulator shifts right.
  assign acc_nxt = {cout_hi, sum_hi, acc_r[WIDTH_B-1:1]};

  somador_n #(.N(PW)) u_negate (
    .a    (~acc_nxt),
    .b    (zero_pw),
    .cin  (1'b1),
    .sum  (neg_sum),
    .cout (neg_cout_unused)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start only matters in IDLE, CALC runs WIDTH_B cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt_r == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode from the current state.
  always_comb begin
    ld   = 1'b0;
    step = 1'b0;
    fin  = 1'b0;
    case (state)
      IDLE:    ld = bus.start;
      CALC: begin
        step = 1'b1;
        fin  = (cnt_r == LAST);
      end
      default: ;
    endcase
  end

  // Operand capture, shift-add iteration and result write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_r     <= 1'b0;
      mag_a_r   <= '0;
      mplier_r  <= '0;
      acc_r     <= '0;
      cnt_r     <= '0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (ld) begin
        neg_r    <= bus.signed_mode & (bus.a[WIDTH_A-1] ^ bus.b[WIDTH_B-1]);
        mag_a_r  <= mag_a_in;
        mplier_r <= mag_b_in;
        acc_r    <= '0;
        cnt_r    <= '0;
      end else if (step) begin
        acc_r    <= acc_nxt;
        mplier_r <= mplier_r >> 1;
        cnt_r    <= cnt_r + 1'b1;
        if (fin) begin
          product_r <= neg_r ? neg_sum : acc_nxt;
          done_r    <= 1'b1;
        end
      end
    end
  end

  assign bus.busy    = (state == CALC);
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq at default 5x5 widths.
module tb_mult_seq;

  localparam int WA = 5;
  localparam int WB = 5;
  localparam int PW = WA + WB;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bif ();

  mult_seq #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;

  // Reference: interpret operands as integers and multiply.
  function automatic logic [PW-1:0] ref_prod(input logic s, input logic [WA-1:0] x,
                                             input logic [WB-1:0] y);
    int xi;
    int yi;
    int p;
    xi = int'(x);
    yi = int'(y);
    if (s && x[WA-1]) xi = xi - (1 << WA);
    if (s && y[WB-1]) yi = yi - (1 << WB);
    p = xi * yi;
    return PW'(p);
  endfunction

  // Launch one operation; scramble inputs after capture unless hold is set.
  task automatic run_op(input logic s, input logic [WA-1:0] x, input logic [WB-1:0] y,
                        input bit hold, output logic [PW-1:0] p, output int lat,
                        output int bcnt);
    bif.signed_mode = s;
    bif.a           = x;
    bif.b           = y;
    bif.start       = 1'b1;
    @(posedge clk); #1;
    bcnt = (bif.busy === 1'b1) ? 1 : 0;
    if (!hold) begin
      bif.start       = 1'b0;
      bif.a           = WA'($urandom);
      bif.b           = WB'($urandom);
      bif.signed_mode = 1'($urandom);
    end
    lat = -1;
    p   = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bif.done === 1'b1) begin
        lat = k;
        p   = bif.product;
        break;
      end
      if (bif.busy === 1'b1) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bif.start       = 1'b0;
    bif.signed_mode = 1'b0;
    bif.a           = '0;
    bif.b           = '0;
    #22;
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bif.busy); end
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bif.done); end
    checks++; if (bif.product !== '0) begin errors++; $display("FAIL reset_product got %0d want 0", bif.product); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bif.busy); end
  endtask

  task automatic test_unsigned_max();
    logic [PW-1:0] p;
    int lat, bc;
    run_op(1'b0, 5'd31, 5'd31, 1'b0, p, lat, bc);
    checks++; if (lat !== 5) begin errors++; $display("FAIL umax_latency got %0d want 5", lat); end
    checks++; if (p !== 10'd961) begin errors++; $display("FAIL umax_product got %0d want 961", p); end
    checks++; if (bc !== 5) begin errors++; $display("FAIL umax_busy_cycles got %0d want 5", bc); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL umax_busy_at_done got %b want 0", bif.busy); end
    @(posedge clk); #1;
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL umax_done_pulse got %b want 0", bif.done); end
    checks++; if (bif.product !== 10'd961) begin errors++; $display("FAIL umax_hold got %0d want 961", bif.product); end
  endtask

  task automatic test_signed_corners();
    logic          sm [3] = '{1'b1, 1'b1, 1'b0};
    logic [WA-1:0] xa [3] = '{5'h10, 5'h1D, 5'h1D};
    logic [WB-1:0] yb [3] = '{5'h10, 5'd7, 5'd7};
    logic [PW-1:0] ex [3] = '{10'h100, 10'h3EB, 10'h0CB};
    logic [PW-1:0] p;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(sm[i], xa[i], yb[i], 1'b0, p, lat, bc);
      checks++;
      if (p !== ex[i]) begin
        errors++;
        $display("FAIL corner%0d_product got 0x%03h want 0x%03h", i, p, ex[i]);
      end
      checks++; if (lat !== 5) begin errors++; $display("FAIL corner%0d_latency got %0d want 5", i, lat); end
    end
  endtask

  task automatic test_zero_back_to_back();
    logic [PW-1:0] p;
    int lat, bc, lat2;
    run_op(1'b0, 5'd0, 5'd25, 1'b1, p, lat, bc);
    checks++; if (p !== '0) begin errors++; $display("FAIL zero_product got %0d want 0", p); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL zero_latency got %0d want 5", lat); end
    bif.signed_mode = 1'b0;
    bif.a           = 5'd5;
    bif.b           = 5'd6;
    lat2 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        bif.start = 1'b0;
        checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", bif.busy); end
        checks++; if (bif.product !== '0) begin errors++; $display("FAIL b2b_hold got %0d want 0", bif.product); end
      end
      if (bif.done === 1'b1) begin
        lat2 = k;
        break;
      end
    end
    checks++; if (lat2 !== 6) begin errors++; $display("FAIL b2b_spacing got %0d want 6", lat2); end
    checks++; if (bif.product !== 10'd30) begin errors++; $display("FAIL b2b_product got %0d want 30", bif.product); end
  endtask

  task automatic test_start_while_busy();
    int lat, extra;
    logic [PW-1:0] p;
    bif.signed_mode = 1'b0;
    bif.a           = 5'd3;
    bif.b           = 5'd4;
    bif.start       = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    @(posedge clk); #1;
    bif.a     = 5'd9;
    bif.b     = 5'd9;
    bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    lat = -1;
    p   = 'x;
    for (int k = 3; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bif.done === 1'b1) begin
        lat = k;
        p   = bif.product;
        break;
      end
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL busy_start_latency got %0d want 5", lat); end
    checks++; if (p !== 10'd12) begin errors++; $display("FAIL busy_start_product got %0d want 12", p); end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bif.done === 1'b1 || bif.busy === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_second_op got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_calc();
    logic [PW-1:0] p;
    int lat, bc, seen;
    bif.signed_mode = 1'b0;
    bif.a           = 5'd31;
    bif.b           = 5'd31;
    bif.start       = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bif.busy); end
    checks++; if (bif.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bif.done); end
    checks++; if (bif.product !== '0) begin errors++; $display("FAIL midrst_product got %0d want 0", bif.product); end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bif.done === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_stale_done got %0d want 0", seen); end
    run_op(1'b0, 5'd2, 5'd3, 1'b0, p, lat, bc);
    checks++; if (p !== 10'd6) begin errors++; $display("FAIL midrst_new_product got %0d want 6", p); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_new_latency got %0d want 5", lat); end
  endtask

  task automatic test_sweep();
    logic [PW-1:0] p, ex;
    int lat, bc;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 32; x++) begin
        for (int y = 0; y < 32; y++) begin
          run_op(1'(s), 5'(x), 5'(y), 1'b0, p, lat, bc);
          ex = ref_prod(1'(s), 5'(x), 5'(y));
          checks++;
          if (p !== ex) begin
            errors++;
            $display("FAIL sweep_product s=%0d a=%0d b=%0d got 0x%03h want 0x%03h", s, x, y, p, ex);
          end
          checks++;
          if (lat !== 5) begin
            errors++;
            $display("FAIL sweep_latency s=%0d a=%0d b=%0d got %0d want 5", s, x, y, lat);
          end
        end
      end
    end
  endtask

  task automatic test_random_gaps();
    logic [PW-1:0] p, ex;
    logic [WA-1:0] x;
    logic [WB-1:0] y;
    logic s;
    int lat, bc, gap;
    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom);
      x = WA'($urandom);
      y = WB'($urandom);
      run_op(s, x, y, 1'b0, p, lat, bc);
      ex = ref_prod(s, x, y);
      checks++;
      if (p !== ex) begin
        errors++;
        $display("FAIL rand_product s=%0d a=0x%02h b=0x%02h got 0x%03h want 0x%03h", s, x, y, p, ex);
      end
      checks++; if (bc !== 5) begin errors++; $display("FAIL rand_busy_cycles got %0d want 5", bc); end
      gap = $urandom_range(3, 0);
      bif.start = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      checks++;
      if (bif.product !== ex) begin
        errors++;
        $display("FAIL rand_hold got 0x%03h want 0x%03h", bif.product, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_zero_back_to_back();
    test_start_while_busy();
    test_reset_mid_calc();
    test_sweep();
    test_random_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
